mem_io_responder: RTL

- Responder end of the byte-serial memory bus driven by the memory controller: one byte per cycle, 0=read / 1=write, one-cycle read latency.
- Decodes each bus cycle to either internal byte RAM or the IO window (addr[17:16]==2'b11).
- IO side is a TX FIFO drained on a valid/ready byte stream and an RX FIFO filled from one.
- Drives the uart-full flag back to the controller so it throttles IO writes.

---
 rtl/mem_io_responder_pkg.sv | 31 +++
 rtl/mem_io_responder_if.sv | 32 +++
 rtl/mem_io_responder_byte_fifo.sv | 57 +++++
 rtl/mem_io_responder.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants, bus-select type and address decode helper for the memory/IO responder.
package mem_io_responder_pkg;

    localparam int          DATA_WIDTH      = 8;
    localparam logic [31:0] IO_ADDRESS      = 32'h0003_0000;
    localparam logic [31:0] IO_CTRL_ADDRESS = 32'h0003_0004;
    localparam logic        TRUE            = 1'b1;
    localparam logic        FALSE           = 1'b0;

    // Where a bus cycle lands: byte RAM, one of the two IO registers, or an unmapped IO hole.
    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IO_DATA,
        SEL_IO_CTRL,
        SEL_IO_NONE
    } bus_sel_e;

    // The IO window is addr[17:16]==2'b11; inside it only the two exact register addresses respond.
    function automatic bus_sel_e decode_sel(input logic [31:0] addr);
        if (addr[17:16] != 2'b11) begin
            return SEL_RAM;
        end else if (addr == IO_ADDRESS) begin
            return SEL_IO_DATA;
        end else if (addr == IO_CTRL_ADDRESS) begin
            return SEL_IO_CTRL;
        end else begin
            return SEL_IO_NONE;
        end
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-serial bus from the memory controller plus the TX/RX byte streams.
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic                  rdy;
    logic                  in_ram_rw;
    logic [31:0]           in_ram_address;
    logic [DATA_WIDTH-1:0] in_ram_data;
    logic [DATA_WIDTH-1:0] out_ram_data;
    logic                  out_uart_full;
    logic                  out_tx_valid;
    logic [DATA_WIDTH-1:0] out_tx_data;
    logic                  in_tx_ready;
    logic                  in_rx_valid;
    logic [DATA_WIDTH-1:0] in_rx_data;
    logic                  out_rx_ready;
    logic                  out_halt;
    logic                  out_tx_overflow;

    modport slave (
        input  rdy, in_ram_rw, in_ram_address, in_ram_data, in_tx_ready, in_rx_valid, in_rx_data,
        output out_ram_data, out_uart_full, out_tx_valid, out_tx_data, out_rx_ready, out_halt,
        output out_tx_overflow
    );

    modport master (
        output rdy, in_ram_rw, in_ram_address, in_ram_data, in_tx_ready, in_rx_valid, in_rx_data,
        input  out_ram_data, out_uart_full, out_tx_valid, out_tx_data, out_rx_ready, out_halt,
        input  out_tx_overflow
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Power-of-two byte FIFO with first-word-fall-through head; a push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; emptiness is tracked purely by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the byte-serial memory bus: byte RAM plus a UART-style IO window backed by TX and RX FIFOs.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_io_responder_if.slave   bus
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [DATA_WIDTH-1:0]     ram [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_index;
    bus_sel_e                  sel;
    logic                      bus_write;
    logic                      bus_read;

    logic                  tx_push_req;
    logic                  tx_push_ok;
    logic                  tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_empty;
    logic                  tx_full;
    logic [TX_CW-1:0]      tx_count;
    logic [TX_CW-1:0]      tx_count_next;

    logic                  rx_push;
    logic                  rx_pop;
    logic [DATA_WIDTH-1:0] rx_head;
    logic                  rx_empty;
    logic                  rx_full;
    logic [RX_CW-1:0]      rx_count;
    logic                  rx_nonempty;

    assign ram_index = bus.in_ram_address[RAM_ADDR_WIDTH-1:0];
    assign sel       = decode_sel(bus.in_ram_address);
    assign bus_write = bus.rdy && bus.in_ram_rw;
    assign bus_read  = bus.rdy && !bus.in_ram_rw;

    assign tx_pop      = !tx_empty && bus.in_tx_ready;
    assign tx_push_req = bus_write && (sel == SEL_IO_DATA);
    assign tx_push_ok  = tx_push_req && (!tx_full || tx_pop);

    assign rx_nonempty = (rx_count != '0);
    assign rx_push     = bus.in_rx_valid && !rx_full;
    assign rx_pop      = bus_read && (sel == SEL_IO_DATA) && !rx_empty;

    assign bus.out_tx_valid = !tx_empty;
    assign bus.out_tx_data  = tx_head;
    assign bus.out_rx_ready = !rx_full;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push_ok),
        .pop      (tx_pop),
        .data_in  (bus.in_ram_data),
        .data_out (tx_head),
        .empty    (tx_empty),
        .full     (tx_full),
        .count    (tx_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .pop      (rx_pop),
        .data_in  (bus.in_rx_data),
        .data_out (rx_head),
        .empty    (rx_empty),
        .full     (rx_full),
        .count    (rx_count)
    );

    // Occupancy the TX FIFO will have after this edge, used to throttle the controller one slot early.
    always_comb begin
        tx_count_next = tx_count + TX_CW'(tx_push_ok) - TX_CW'(tx_pop);
    end

    // Byte RAM writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bus_write && (sel == SEL_RAM)) begin
            ram[ram_index] <= bus.in_ram_data;
        end
    end

    // Registered bus-side outputs: read data, throttle flag, halt pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.out_ram_data    <= '0;
            bus.out_uart_full   <= FALSE;
            bus.out_halt        <= FALSE;
            bus.out_tx_overflow <= FALSE;
        end else begin
            bus.out_uart_full <= (tx_count_next >= TX_CW'(TX_DEPTH - 1));
            bus.out_halt      <= bus_write && (sel == SEL_IO_CTRL);
            if (tx_push_req && tx_full && !tx_pop) begin
                bus.out_tx_overflow <= TRUE;
            end
            if (bus_read) begin
                unique case (sel)
                    SEL_RAM:     bus.out_ram_data <= ram[ram_index];
                    SEL_IO_DATA: bus.out_ram_data <= rx_empty ? '0 : rx_head;
                    SEL_IO_CTRL: bus.out_ram_data <= {6'b0, rx_nonempty, tx_full};
                    default:     bus.out_ram_data <= '0;
                endcase
            end
        end
    end

endmodule
